// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - ID->EX->MEM->WB control/destination pipeline with bubble insertion and hold
module pipe_ctrl_chain #(
    parameter int AW    = 5,
    parameter int ALUCW = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             stall,
    input  logic             flush,
    input  logic             wrf_id,
    input  logic             wdc_id,
    input  logic             aludc_id,
    input  logic             wena_id,
    input  logic [ALUCW-1:0] aluc_id,
    input  logic [AW-1:0]    wa_id,
    output logic             wrf_exe,
    output logic             wdc_exe,
    output logic             aludc_exe,
    output logic             wena_exe,
    output logic [ALUCW-1:0] aluc_exe,
    output logic [AW-1:0]    wa_exe,
    output logic             wrf_mem,
    output logic             wdc_mem,
    output logic             aludc_mem,
    output logic             wena_mem,
    output logic [AW-1:0]    wa_mem,
    output logic             wrf_wb,
    output logic             wdc_wb,
    output logic [AW-1:0]    wa_wb,
    output logic [CNTW-1:0]  bubble_cnt
);

    logic w_bubble;
    logic w_wrf_id_eff;

    assign w_bubble     = stall | flush;
    // Writes to register 0 are dropped early so the hazard comparators never match on it.
    assign w_wrf_id_eff = wrf_id & (wa_id != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrf_exe    <= 1'b0;
            wdc_exe    <= 1'b0;
            aludc_exe  <= 1'b0;
            wena_exe   <= 1'b0;
            aluc_exe   <= '0;
            wa_exe     <= '0;
            wrf_mem    <= 1'b0;
            wdc_mem    <= 1'b0;
            aludc_mem  <= 1'b0;
            wena_mem   <= 1'b0;
            wa_mem     <= '0;
            wrf_wb     <= 1'b0;
            wdc_wb     <= 1'b0;
            wa_wb      <= '0;
            bubble_cnt <= '0;
        end else if (!hold) begin
            if (w_bubble) begin
                wrf_exe   <= 1'b0;
                wdc_exe   <= 1'b0;
                aludc_exe <= 1'b0;
                wena_exe  <= 1'b0;
                aluc_exe  <= '0;
                wa_exe    <= '0;
                if (bubble_cnt != {CNTW{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end else begin
                wrf_exe   <= w_wrf_id_eff;
                wdc_exe   <= wdc_id;
                aludc_exe <= aludc_id;
                wena_exe  <= wena_id;
                aluc_exe  <= aluc_id;
                wa_exe    <= wa_id;
            end
            // Older instructions keep moving even while EX takes a bubble.
            wrf_mem   <= wrf_exe;
            wdc_mem   <= wdc_exe;
            aludc_mem <= aludc_exe;
            wena_mem  <= wena_exe;
            wa_mem    <= wa_exe;
            wrf_wb    <= wrf_mem;
            wdc_wb    <= wdc_mem;
            wa_wb     <= wa_mem;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - self-checking bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

    logic       clk = 1'b0;
    logic       rst, hold, stall, flush;
    logic       wrf_id, wdc_id, aludc_id, wena_id;
    logic [3:0] aluc_id;
    logic [4:0] wa_id;

    logic       wrf_exe, wdc_exe, aludc_exe, wena_exe;
    logic [3:0] aluc_exe;
    logic [4:0] wa_exe;
    logic       wrf_mem, wdc_mem, aludc_mem, wena_mem;
    logic [4:0] wa_mem;
    logic       wrf_wb, wdc_wb;
    logic [4:0] wa_wb;
    logic [15:0] bubble_cnt;

    logic       s_wrf_exe, s_wdc_exe, s_aludc_exe, s_wena_exe;
    logic [3:0] s_aluc_exe;
    logic [4:0] s_wa_exe;
    logic       s_wrf_mem, s_wdc_mem, s_aludc_mem, s_wena_mem;
    logic [4:0] s_wa_mem;
    logic       s_wrf_wb, s_wdc_wb;
    logic [4:0] s_wa_wb;
    logic [1:0] s_bubble_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(.AW(5), .ALUCW(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .stall(stall), .flush(flush),
        .wrf_id(wrf_id), .wdc_id(wdc_id), .aludc_id(aludc_id), .wena_id(wena_id),
        .aluc_id(aluc_id), .wa_id(wa_id),
        .wrf_exe(wrf_exe), .wdc_exe(wdc_exe), .aludc_exe(aludc_exe), .wena_exe(wena_exe),
        .aluc_exe(aluc_exe), .wa_exe(wa_exe),
        .wrf_mem(wrf_mem), .wdc_mem(wdc_mem), .aludc_mem(aludc_mem), .wena_mem(wena_mem),
        .wa_mem(wa_mem), .wrf_wb(wrf_wb), .wdc_wb(wdc_wb), .wa_wb(wa_wb),
        .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl_chain #(.AW(5), .ALUCW(4), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold), .stall(stall), .flush(flush),
        .wrf_id(wrf_id), .wdc_id(wdc_id), .aludc_id(aludc_id), .wena_id(wena_id),
        .aluc_id(aluc_id), .wa_id(wa_id),
        .wrf_exe(s_wrf_exe), .wdc_exe(s_wdc_exe), .aludc_exe(s_aludc_exe), .wena_exe(s_wena_exe),
        .aluc_exe(s_aluc_exe), .wa_exe(s_wa_exe),
        .wrf_mem(s_wrf_mem), .wdc_mem(s_wdc_mem), .aludc_mem(s_aludc_mem), .wena_mem(s_wena_mem),
        .wa_mem(s_wa_mem), .wrf_wb(s_wrf_wb), .wdc_wb(s_wdc_wb), .wa_wb(s_wa_wb),
        .bubble_cnt(s_bubble_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-flight instruction list, front = EX, back = WB.
    typedef struct {
        bit wrf, wdc, aludc, wena;
        int aluc, wa;
    } instr_t;

    instr_t pipe[$];
    int     m_cnt, m_cnt_sat;

    task automatic model_reset();
        instr_t z;
        z = '{0, 0, 0, 0, 0, 0};
        pipe = {};
        for (int i = 0; i < 3; i++) pipe.push_back(z);
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    task automatic model_edge();
        instr_t n;
        bit bub;
        if (rst) begin
            model_reset();
            return;
        end
        if (hold) return;
        bub = stall || flush;
        if (bub) begin
            n = '{0, 0, 0, 0, 0, 0};
            m_cnt     = (m_cnt     < 65535) ? m_cnt + 1     : 65535;
            m_cnt_sat = (m_cnt_sat < 3)     ? m_cnt_sat + 1 : 3;
        end else begin
            n.wrf   = wrf_id && (wa_id != 0);
            n.wdc   = wdc_id;
            n.aludc = aludc_id;
            n.wena  = wena_id;
            n.aluc  = int'(aluc_id);
            n.wa    = int'(wa_id);
        end
        pipe.push_front(n);
        void'(pipe.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic compare_all();
        check("wrf_exe",    32'(wrf_exe),    int'(pipe[0].wrf));
        check("wdc_exe",    32'(wdc_exe),    int'(pipe[0].wdc));
        check("aludc_exe",  32'(aludc_exe),  int'(pipe[0].aludc));
        check("wena_exe",   32'(wena_exe),   int'(pipe[0].wena));
        check("aluc_exe",   32'(aluc_exe),   pipe[0].aluc);
        check("wa_exe",     32'(wa_exe),     pipe[0].wa);
        check("wrf_mem",    32'(wrf_mem),    int'(pipe[1].wrf));
        check("wdc_mem",    32'(wdc_mem),    int'(pipe[1].wdc));
        check("aludc_mem",  32'(aludc_mem),  int'(pipe[1].aludc));
        check("wena_mem",   32'(wena_mem),   int'(pipe[1].wena));
        check("wa_mem",     32'(wa_mem),     pipe[1].wa);
        check("wrf_wb",     32'(wrf_wb),     int'(pipe[2].wrf));
        check("wdc_wb",     32'(wdc_wb),     int'(pipe[2].wdc));
        check("wa_wb",      32'(wa_wb),      pipe[2].wa);
        check("bubble_cnt", 32'(bubble_cnt), m_cnt);
        check("sat_cnt",    32'(s_bubble_cnt), m_cnt_sat);
    endtask

    typedef struct {
        bit rst, hold, stall, flush, wrf, wdc, aludc, wena;
        int aluc, wa;
        int e_wrf_exe, e_wa_exe, e_wdc_mem, e_wa_mem, e_wrf_wb, e_wa_wb, e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, h, s, f, wrf, wdc, input int aluc, wa,
                       input int ewe, ewae, edm, ewam, ewrw, ewaw, ecnt);
        vec_t v;
        v = '{r, h, s, f, wrf, wdc, 1'b0, 1'b0, aluc, wa, ewe, ewae, edm, ewam, ewrw, ewaw, ecnt};
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        rst = 0; hold = 0; stall = 0; flush = 0;
        wrf_id = 0; wdc_id = 0; aludc_id = 0; wena_id = 0; aluc_id = 0; wa_id = 0;
    endtask

    initial begin
        drive_idle();
        model_reset();

        //  rst h s f wrf wdc aluc wa | wrf_exe wa_exe wdc_mem wa_mem wrf_wb wa_wb cnt
        add(1, 0, 0, 0, 1, 0, 3,  7,   0, 0,  0, 0, 0, 0, 0);  // reset with live ID inputs
        add(1, 0, 1, 0, 0, 1, 9,  12,  0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,  9,   1, 9,  0, 0, 0, 0, 0);  // flow of reg 9
        add(0, 0, 0, 0, 0, 0, 0,  0,   0, 0,  0, 9, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,  0,   0, 0,  0, 0, 1, 9, 0);
        add(0, 0, 0, 0, 0, 0, 0,  0,   0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0,  8,   1, 8,  0, 0, 0, 0, 0);  // lw r8
        add(0, 0, 1, 0, 1, 0, 2,  3,   0, 0,  1, 8, 0, 0, 1);  // load-use stall
        add(0, 0, 0, 0, 1, 0, 2,  3,   1, 3,  0, 0, 1, 8, 1);
        add(0, 1, 1, 0, 1, 0, 5,  20,  1, 3,  0, 0, 1, 8, 1);  // hold x3
        add(0, 1, 1, 1, 0, 1, 6,  21,  1, 3,  0, 0, 1, 8, 1);
        add(0, 1, 0, 0, 1, 1, 7,  22,  1, 3,  0, 0, 1, 8, 1);
        add(0, 0, 0, 0, 0, 0, 0,  0,   0, 0,  0, 3, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 1,  4,   0, 0,  0, 0, 1, 3, 2);  // stall+flush = one bubble
        add(0, 0, 0, 0, 1, 1, 0,  0,   0, 0,  0, 0, 0, 0, 2);  // $0 suppression
        add(0, 0, 0, 0, 0, 0, 0,  0,   0, 0,  1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 1, 0, 0,  31,  1, 31, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0,  0,   1, 31, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 1, 1, 4,  17,  0, 0,  0, 0, 0, 0, 0);  // rst beats hold

        @(negedge clk);
        foreach (vq[i]) begin
            rst = vq[i].rst; hold = vq[i].hold; stall = vq[i].stall; flush = vq[i].flush;
            wrf_id = vq[i].wrf; wdc_id = vq[i].wdc; aludc_id = vq[i].aludc; wena_id = vq[i].wena;
            aluc_id = 4'(vq[i].aluc); wa_id = 5'(vq[i].wa);
            step();
            check($sformatf("v%0d wrf_exe", i), 32'(wrf_exe), vq[i].e_wrf_exe);
            check($sformatf("v%0d wa_exe", i),  32'(wa_exe),  vq[i].e_wa_exe);
            check($sformatf("v%0d wdc_mem", i), 32'(wdc_mem), vq[i].e_wdc_mem);
            check($sformatf("v%0d wa_mem", i),  32'(wa_mem),  vq[i].e_wa_mem);
            check($sformatf("v%0d wrf_wb", i),  32'(wrf_wb),  vq[i].e_wrf_wb);
            check($sformatf("v%0d wa_wb", i),   32'(wa_wb),   vq[i].e_wa_wb);
            check($sformatf("v%0d cnt", i),     32'(bubble_cnt), vq[i].e_cnt);
        end
        check("post-table model", 32'(wdc_exe), int'(pipe[0].wdc));

        // Saturation of the 2-bit counter: 5 stalls, then a held stall.
        drive_idle();
        rst = 1; step(); rst = 0;
        for (int k = 1; k <= 5; k++) begin
            stall = 1; wrf_id = 1; wa_id = 5'(k);
            step();
            check($sformatf("sat stall%0d", k), 32'(s_bubble_cnt), (k < 3) ? k : 3);
            check($sformatf("wide stall%0d", k), 32'(bubble_cnt), k);
        end
        hold = 1; step();
        check("sat held", 32'(s_bubble_cnt), 3);
        check("wide held", 32'(bubble_cnt), 5);
        drive_idle();

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            hold     = ($urandom_range(0, 4) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 5) == 0);
            wrf_id   = 1'($urandom);
            wdc_id   = 1'($urandom);
            aludc_id = 1'($urandom);
            wena_id  = 1'($urandom);
            aluc_id  = 4'($urandom);
            wa_id    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step();
            compare_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
